mem_stream_loader: RTL and testbench

//  Sequencer on the port side of the banked single-port memory (mem_single).

---
 rtl/mem_stream_loader_if.sv | 35 +++
 rtl/mem_stream_loader.sv | 153 +++++++++++++++
 tb/tb_mem_stream_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stream_loader_if.sv
// Purpose: bundles the control, byte-stream, memory-port and word-stream signals of mem_stream_loader.
// Latency: none; this file only declares wires.
// Backpressure: in_valid/in_ready on the input stream, out_valid/out_ready on the output stream.
interface mem_stream_loader_if #(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 8,
    parameter int ADDR_W   = 17
);
    logic                start_load;
    logic                start_dump;
    logic [IN_WIDTH-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   mem_address;
    logic [WIDTH-1:0]    mem_data;
    logic                mem_wr_en;
    logic [WIDTH-1:0]    mem_q;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                done;

    // Sequencer side.
    modport slave (
        input  start_load, start_dump, in_data, in_valid, mem_q, out_ready,
        output in_ready, mem_address, mem_data, mem_wr_en, out_data, out_valid, busy, done
    );

    // Host / memory / sink side.
    modport master (
        output start_load, start_dump, in_data, in_valid, mem_q, out_ready,
        input  in_ready, mem_address, mem_data, mem_wr_en, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/mem_stream_loader.sv
// Purpose: packs a narrow beat stream into words written to memory from address 0 (LOAD), or reads the range back out as a word stream (DUMP).
// Latency: a completed word is on the memory port the cycle after its last beat; a dumped word appears 2 cycles after its read address.
// Backpressure: in_ready is high only while loading; out_data is held with out_valid until out_ready.
module mem_stream_loader #(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 8,
    parameter int N_WORDS  = 1024,
    parameter int ADDR_W   = 17
) (
    input  logic                clock,
    input  logic                reset,
    mem_stream_loader_if.slave  bus
);
    localparam int BEATS  = WIDTH / IN_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLUSH, S_RD_ADDR, S_RD_CAP, S_OUT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]  pack_q, pack_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [WIDTH-1:0]  mem_data_q, mem_data_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic [WIDTH-1:0]  packed_word;

    // Next-state and next-output logic; every output is taken from a flop.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        idx_d         = idx_q;
        pack_d        = pack_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wr_en_d   = 1'b0;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        accept        = in_ready_q & bus.in_valid;
        // Earlier beats move up so the first beat of a word ends in the MSBs.
        packed_word   = (pack_q << IN_WIDTH) | WIDTH'(bus.in_data);

        case (state_q)
            S_IDLE: begin
                if (bus.start_load) begin
                    state_d       = S_LOAD;
                    idx_d         = '0;
                    beat_d        = '0;
                    pack_d        = '0;
                    mem_address_d = '0;
                end else if (bus.start_dump) begin
                    state_d       = S_RD_ADDR;
                    idx_d         = '0;
                    mem_address_d = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        mem_wr_en_d   = 1'b1;
                        mem_data_d    = packed_word;
                        mem_address_d = idx_q;
                        beat_d        = '0;
                        pack_d        = '0;
                        if (idx_q == LAST_WORD) begin
                            state_d = S_FLUSH;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        pack_d = packed_word;
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FLUSH:   state_d = S_DONE;
            S_RD_ADDR: state_d = S_RD_CAP;
            S_RD_CAP: begin
                out_data_d  = bus.mem_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d         = idx_q + 1'b1;
                        mem_address_d = idx_q + 1'b1;
                        state_d       = S_RD_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any transfer in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            idx_q         <= '0;
            pack_q        <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wr_en_q   <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            idx_q         <= idx_d;
            pack_q        <= pack_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wr_en_q   <= mem_wr_en_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_mem_stream_loader.sv
// Purpose: directed bench for mem_stream_loader with a 16-bit/4-word instance and an 8-bit/1-word instance.
// Latency: expects writes the cycle after a word's last beat and done two cycles after the final beat.
// Backpressure: toggles out_ready while dumping and gaps in_valid while loading.
module tb_mem_stream_loader;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_stream_loader_if #(.WIDTH(16), .IN_WIDTH(8), .ADDR_W(17)) a ();
    mem_stream_loader_if #(.WIDTH(8),  .IN_WIDTH(8), .ADDR_W(17)) b ();

    mem_stream_loader #(.WIDTH(16), .IN_WIDTH(8), .N_WORDS(4), .ADDR_W(17)) dut_a (
        .clock(clock), .reset(reset), .bus(a.slave));
    mem_stream_loader #(.WIDTH(8), .IN_WIDTH(8), .N_WORDS(1), .ADDR_W(17)) dut_b (
        .clock(clock), .reset(reset), .bus(b.slave));

    typedef logic [48:0] wr_t;
    wr_t         wr_qa[$];
    wr_t         wr_qb[$];
    logic [15:0] rd_qa[$];
    logic [7:0]  rd_qb[$];
    logic [15:0] words[4];
    int          vec_cnt = 0;
    int          err_cnt = 0;

    // Single-port memories with one cycle of read latency.
    logic [15:0] mem_a[16];
    logic [7:0]  mem_b[4];
    always @(posedge clock) begin
        if (a.mem_wr_en) mem_a[a.mem_address[3:0]] <= a.mem_data;
        a.mem_q <= mem_a[a.mem_address[3:0]];
        if (b.mem_wr_en) mem_b[b.mem_address[1:0]] <= b.mem_data;
        b.mem_q <= mem_b[b.mem_address[1:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the next expected write.
    always @(negedge clock) begin
        wr_t e;
        if (a.mem_wr_en) begin
            e = (wr_qa.size() > 0) ? wr_qa.pop_front() : '1;
            check("wr_a", 64'({a.mem_address, 32'(a.mem_data)}), 64'(e));
        end
        if (b.mem_wr_en) begin
            e = (wr_qb.size() > 0) ? wr_qb.pop_front() : '1;
            check("wr_b", 64'({b.mem_address, 32'(b.mem_data)}), 64'(e));
        end
    end

    // Every cycle with out_valid must show the expected word; pop on handshake.
    always @(negedge clock) begin
        if (a.out_valid) begin
            check("dump_a", 64'(a.out_data), (rd_qa.size() > 0) ? 64'(rd_qa[0]) : '1);
            if (a.out_ready && rd_qa.size() > 0) void'(rd_qa.pop_front());
        end
        if (b.out_valid) begin
            check("dump_b", 64'(b.out_data), (rd_qb.size() > 0) ? 64'(rd_qb[0]) : '1);
            if (b.out_ready && rd_qb.size() > 0) void'(rd_qb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat_a(input logic [7:0] d);
        logic ok = 1'b0;
        a.in_data  = d;
        a.in_valid = 1'b1;
        for (int k = 0; k < 16 && !ok; k++) begin
            @(negedge clock);
            ok = a.in_ready;
            tick();
        end
        a.in_valid = 1'b0;
        check("beat_a_accept", 64'(ok), 64'd1);
    endtask

    task automatic load_a(input bit gap, input bit both);
        for (int i = 0; i < 4; i++) wr_qa.push_back({17'(i), 32'(words[i])});
        a.start_load = 1'b1;
        a.start_dump = both;
        tick();
        a.start_load = 1'b0;
        a.start_dump = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (both && i == 0) a.start_dump = 1'b1;
            beat_a(words[i][15:8]);
            a.start_dump = 1'b0;
            if (gap) tick();
            beat_a(words[i][7:0]);
            if (gap && i < 3) tick();
        end
        @(negedge clock);
        check("flush_in_ready", 64'(a.in_ready), 64'd0);
        check("flush_wr_en", 64'(a.mem_wr_en), 64'd1);
        check("flush_done", 64'(a.done), 64'd0);
        tick();
        @(negedge clock);
        check("done_pulse", 64'(a.done), 64'd1);
        check("done_busy", 64'(a.busy), 64'd1);
        tick();
        @(negedge clock);
        check("idle_done", 64'(a.done), 64'd0);
        check("idle_busy", 64'(a.busy), 64'd0);
        tick();
        check("wr_qa_drained", 64'(wr_qa.size()), 64'd0);
    endtask

    task automatic dump_a();
        int dn = 0;
        for (int i = 0; i < 4; i++) rd_qa.push_back(words[i]);
        a.start_dump = 1'b1;
        tick();
        a.start_dump = 1'b0;
        for (int c = 0; c < 40; c++) begin
            a.out_ready = (c % 2 == 0);
            @(negedge clock);
            if (a.done) begin
                dn++;
                check("dump_a_done_after_last", 64'(rd_qa.size()), 64'd0);
            end
            tick();
        end
        a.out_ready = 1'b0;
        check("dump_a_done_count", 64'(dn), 64'd1);
        check("dump_a_drained", 64'(rd_qa.size()), 64'd0);
        check("dump_a_idle", 64'(a.busy), 64'd0);
    endtask

    initial begin
        int dn;
        a.start_load = 0; a.start_dump = 0; a.in_data = 0; a.in_valid = 0; a.out_ready = 0;
        b.start_load = 0; b.start_dump = 0; b.in_data = 0; b.in_valid = 0; b.out_ready = 0;
        reset = 1'b1;
        repeat (3) tick();

        // Reset state.
        @(negedge clock);
        check("rst_in_ready", 64'(a.in_ready), 64'd0);
        check("rst_wr_en", 64'(a.mem_wr_en), 64'd0);
        check("rst_address", 64'(a.mem_address), 64'd0);
        check("rst_mem_data", 64'(a.mem_data), 64'd0);
        check("rst_out_data", 64'(a.out_data), 64'd0);
        check("rst_out_valid", 64'(a.out_valid), 64'd0);
        check("rst_busy", 64'(a.busy), 64'd0);
        check("rst_done", 64'(a.done), 64'd0);
        check("rst_b_busy", 64'({b.busy, b.in_ready, b.mem_wr_en, b.done}), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Reset in the middle of a word: the half word must never be written.
        a.start_load = 1'b1;
        tick();
        a.start_load = 1'b0;
        beat_a(8'h11);
        @(negedge clock);
        check("load_busy", 64'(a.busy), 64'd1);
        check("load_in_ready", 64'(a.in_ready), 64'd1);
        a.in_data  = 8'h22;
        a.in_valid = 1'b1;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        a.in_valid = 1'b0;
        @(negedge clock);
        check("abort_busy", 64'(a.busy), 64'd0);
        check("abort_wr_en", 64'(a.mem_wr_en), 64'd0);
        check("abort_in_ready", 64'(a.in_ready), 64'd0);
        check("abort_done", 64'(a.done), 64'd0);
        tick();

        // Back-to-back load, then gapped load of the same data.
        words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        load_a(1'b0, 1'b0);
        load_a(1'b1, 1'b0);

        // Dump with out_ready toggling.
        dump_a();

        // Simultaneous starts pick LOAD; a dump request mid-load is ignored.
        words = '{16'h0102, 16'hA0B0, 16'hFFEE, 16'h7F80};
        load_a(1'b0, 1'b1);
        repeat (3) tick();
        @(negedge clock);
        check("after_load_out_valid", 64'(a.out_valid), 64'd0);
        check("after_load_busy", 64'(a.busy), 64'd0);
        tick();
        dump_a();

        // One-byte words, one-word transfer.
        wr_qb.push_back({17'd0, 32'h0000_00A5});
        b.start_load = 1'b1;
        tick();
        b.start_load = 1'b0;
        b.in_data  = 8'hA5;
        b.in_valid = 1'b1;
        @(negedge clock);
        check("b_in_ready", 64'(b.in_ready), 64'd1);
        tick();
        b.in_valid = 1'b0;
        @(negedge clock);
        check("b_flush_in_ready", 64'(b.in_ready), 64'd0);
        check("b_flush_wr_en", 64'(b.mem_wr_en), 64'd1);
        check("b_flush_busy", 64'(b.busy), 64'd1);
        check("b_flush_done", 64'(b.done), 64'd0);
        tick();
        @(negedge clock);
        check("b_done", 64'(b.done), 64'd1);
        check("b_done_wr_en", 64'(b.mem_wr_en), 64'd0);
        tick();
        @(negedge clock);
        check("b_idle_busy", 64'(b.busy), 64'd0);
        check("b_idle_done", 64'(b.done), 64'd0);
        tick();

        // Read the single word back.
        rd_qb.push_back(8'hA5);
        b.out_ready  = 1'b1;
        b.start_dump = 1'b1;
        tick();
        b.start_dump = 1'b0;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (b.done) dn++;
            tick();
        end
        b.out_ready = 1'b0;
        check("b_dump_done_count", 64'(dn), 64'd1);
        check("b_dump_drained", 64'(rd_qb.size()), 64'd0);
        check("wr_qb_drained", 64'(wr_qb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
